// File: rtl/result_display.sv
// result_display: feedback stage of the guess-the-number game.
// Shows result messages, a blinking win banner and a BCD guess count.
module result_display #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int MAX_COUNT    = 99
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_button,
  input  logic       Guess_button,
  input  logic [2:0] state,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       win,
  output logic [7:0] guesses
);

  localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);
  localparam logic [7:0] MAX_BCD = {MAX_T, MAX_O};

  localparam logic [6:0] C_BLANK = 7'h7F;
  localparam logic [6:0] C_DASH  = 7'b0111111;
  localparam logic [6:0] C_G     = 7'b1000010;
  localparam logic [6:0] C_O     = 7'b0100011;
  localparam logic [6:0] C_L     = 7'b1000111;
  localparam logic [6:0] C_H     = 7'b0001001;
  localparam logic [6:0] C_I     = 7'b1111001;
  localparam logic [6:0] C_D     = 7'b0100001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_WIN
  } fsm_t;

  fsm_t          fsm;
  fsm_t          fsm_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          phase;
  logic          phase_next;
  logic          hist;
  logic          press;
  logic [7:0]    count_next;
  logic [27:0]   msg_next;
  logic [6:0]    tens_seg;
  logic [6:0]    ones_seg;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = C_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    fsm_next = fsm;
    case (state)
      3'd0: fsm_next = S_IDLE;
      3'd1: fsm_next = S_PLAY;
      3'd2,
      3'd3: if (fsm == S_IDLE) fsm_next = S_PLAY;
      3'd4: fsm_next = S_WIN;
      default: fsm_next = fsm;
    endcase
  end

  // Blink restarts in the on phase whenever WIN is (re)entered.
  always_comb begin
    cnt_next   = '0;
    phase_next = 1'b1;
    if (fsm == S_WIN && fsm_next == S_WIN) begin
      if (cnt == LAST) begin
        cnt_next   = '0;
        phase_next = ~phase;
      end else begin
        cnt_next   = cnt + 1'b1;
        phase_next = phase;
      end
    end
  end

  assign press = hist & ~Guess_button;

  always_comb begin
    count_next = guesses;
    if (!Start_button || fsm == S_IDLE) begin
      count_next = 8'h00;
    end else if (press && fsm == S_PLAY && guesses != MAX_BCD) begin
      if (guesses[3:0] == 4'd9) begin
        count_next[3:0] = 4'd0;
        count_next[7:4] = guesses[7:4] + 4'd1;
      end else begin
        count_next[3:0] = guesses[3:0] + 4'd1;
      end
    end
  end

  always_comb begin
    msg_next = {4{C_BLANK}};
    case (state)
      3'd0: msg_next = {4{C_DASH}};
      3'd1: msg_next = {C_BLANK, C_BLANK, C_G, C_O};
      3'd2: msg_next = {C_BLANK, C_BLANK, C_L, C_O};
      3'd3: msg_next = {C_BLANK, C_BLANK, C_H, C_I};
      3'd4: if (phase_next) msg_next = {C_G, C_O, C_O, C_D};
      default: msg_next = {4{C_BLANK}};
    endcase
  end

  assign ones_seg = seg_digit(count_next[3:0]);
  assign tens_seg = (count_next[7:4] == 4'd0) ? C_BLANK
                  : seg_digit(count_next[7:4]);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      fsm     <= S_IDLE;
      cnt     <= '0;
      phase   <= 1'b1;
      hist    <= 1'b1;
      guesses <= 8'h00;
      win     <= 1'b0;
      HEX3    <= C_DASH;
      HEX2    <= C_DASH;
      HEX1    <= C_DASH;
      HEX0    <= C_DASH;
      HEX4    <= 7'b1000000;
      HEX5    <= C_BLANK;
    end else begin
      fsm     <= fsm_next;
      cnt     <= cnt_next;
      phase   <= phase_next;
      hist    <= Guess_button;
      guesses <= count_next;
      win     <= (fsm_next == S_WIN);
      HEX3    <= msg_next[27:21];
      HEX2    <= msg_next[20:14];
      HEX1    <= msg_next[13:7];
      HEX0    <= msg_next[6:0];
      HEX4    <= ones_seg;
      HEX5    <= tens_seg;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed checks of the game feedback stage.
// Table vectors for the main flow, hand sequences for blink and saturation.
module tb_result_display;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start_button;
  logic       Guess_button;
  logic [2:0] state;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       win;
  logic [7:0] guesses;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  result_display #(
    .BLINK_CYCLES(4),
    .MAX_COUNT(99)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start_button(Start_button),
    .Guess_button(Guess_button),
    .state(state),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .HEX4(HEX4),
    .HEX5(HEX5),
    .win(win),
    .guesses(guesses)
  );

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'b0111111;
  localparam logic [6:0] CG = 7'b1000010;
  localparam logic [6:0] CO = 7'b0100011;
  localparam logic [6:0] CL = 7'b1000111;
  localparam logic [6:0] CH = 7'b0001001;
  localparam logic [6:0] CI = 7'b1111001;
  localparam logic [6:0] CD = 7'b0100001;

  localparam logic [27:0] M_DASH  = {DS, DS, DS, DS};
  localparam logic [27:0] M_GO    = {BL, BL, CG, CO};
  localparam logic [27:0] M_LO    = {BL, BL, CL, CO};
  localparam logic [27:0] M_HI    = {BL, BL, CH, CI};
  localparam logic [27:0] M_GOOD  = {CG, CO, CO, CD};
  localparam logic [27:0] M_BLANK = {BL, BL, BL, BL};

  typedef struct {
    logic        rst;
    logic        start;
    logic        guess;
    logic [2:0]  st;
    logic [27:0] msg;
    logic        w;
    logic [7:0]  g;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = BL;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] cnt_segs(input logic [7:0] g);
    logic [6:0] t;
    t = (g[7:4] == 4'd0) ? BL : digit(g[7:4]);
    return {t, digit(g[3:0])};
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic step(input logic r, input logic s,
                      input logic g, input logic [2:0] st);
    Reset        = r;
    Start_button = s;
    Guess_button = g;
    state        = st;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [27:0] msg,
                         input logic w, input logic [7:0] g);
    chk({tag, " msg"}, {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, msg});
    chk({tag, " win"}, {31'h0, win}, {31'h0, w});
    chk({tag, " guesses"}, {24'h0, guesses}, {24'h0, g});
    chk({tag, " count segs"}, {18'h0, HEX5, HEX4}, {18'h0, cnt_segs(g)});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 3'd0, M_DASH,  1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 3'd1, M_GO,    1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'd2, M_LO,    1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd2, M_LO,    1'b0, 8'h01};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3'd2, M_LO,    1'b0, 8'h01};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd2, M_LO,    1'b0, 8'h02};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'd2, M_LO,    1'b0, 8'h02};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd2, M_LO,    1'b0, 8'h03};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 3'd2, M_LO,    1'b0, 8'h03};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd5, M_BLANK, 1'b0, 8'h03};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd7, M_BLANK, 1'b0, 8'h04};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'd3, M_HI,    1'b0, 8'h04};

    step(1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0);
    chk_all("reset", M_DASH, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].guess, vecs[i].st);
      chk_all($sformatf("vec%0d", i), vecs[i].msg, vecs[i].w, vecs[i].g);
    end

    // Held button counts once.
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd3);
      if (i == 0) chk_all("held first", M_HI, 1'b0, 8'h05);
    end
    chk_all("held end", M_HI, 1'b0, 8'h05);
    step(1'b1, 1'b1, 1'b1, 3'd3);
    chk_all("held release", M_HI, 1'b0, 8'h05);

    // Press coincident with first state==4 counts; presses in WIN do not.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, (i % 2 == 1), 3'd4);
      chk_all($sformatf("blink%0d", i),
              ((i % 8) < 4) ? M_GOOD : M_BLANK, 1'b1, 8'h06);
    end
    step(1'b1, 1'b1, 1'b1, 3'd6);
    chk_all("win invalid", M_BLANK, 1'b1, 8'h06);

    step(1'b1, 1'b0, 1'b1, 3'd1);
    chk_all("new game", M_GO, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 3'd1);
    chk_all("new game hold", M_GO, 1'b0, 8'h00);

    for (int i = 1; i <= 99; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd2);
      step(1'b1, 1'b1, 1'b1, 3'd2);
      if (i == 1 || i == 9 || i == 10 || i == 99)
        chk_all($sformatf("count%0d", i), M_LO, 1'b0, to_bcd(i));
    end
    step(1'b1, 1'b1, 1'b0, 3'd2);
    chk_all("saturate", M_LO, 1'b0, 8'h99);
    chk("saturate hex5", {25'h0, HEX5}, {25'h0, 7'b0010000});
    chk("saturate hex4", {25'h0, HEX4}, {25'h0, 7'b0010000});

    step(1'b0, 1'b1, 1'b1, 3'd2);
    chk_all("reset mid", M_DASH, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 3'd2);
    chk_all("after reset", M_LO, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Feedback stage of the guess-the-number game. Consumes the 3-bit result code from the guess comparator, plus the raw Start and Guess push-buttons. Drives six active-low 7-segment displays with a message for the current result and a 2-digit BCD count of guesses made this game. On a correct guess it flashes the win message at a fixed rate until a new game starts.

## Interface
Parameters:
- BLINK_CYCLES, 25_000_000, clock cycles per half-period of the win blink (on time = off time); must be ≥ 2
- MAX_COUNT, 99, saturation value of the guess counter (BCD, ≤ 99)

Ports (name, direction, width, meaning):
- Clock, input, 1, system clock; all logic on rising edge
- Reset, input, 1, synchronous, active-low; one clock; reset is synchronous and active-low
- Start_button, input, 1, active-low level, new game
- Guess_button, input, 1, active-low level, guess submit
- state, input, 3, result code: 0 idle, 1 started, 2 guess low, 3 guess high, 4 equal, 5–7 invalid
- HEX0, HEX1, HEX2, HEX3, output, 7 each, message digits, HEX3 leftmost
- HEX4, HEX5, output, 7 each, guess count ones and tens digits
- win, output, 1, high while in WIN
- guesses, output, 8, BCD guess count {tens, ones}

## Operation
- Segment encoding: active-low, bit order {g,f,e,d,c,b,a}.
  - Characters: blank 7'h7F, '-' 7'b0111111, G 7'b1000010, o 7'b0100011, L 7'b1000111, H 7'b0001001, I 7'b1111001, d 7'b0100001.
  - Digits: standard active-low patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 3 = 7'b0110000, 9 = 7'b0010000.
- FSM states: IDLE, PLAY, WIN.
  - IDLE → PLAY when state ∈ {1,2,3}.
  - Any → WIN when state == 4.
  - WIN → PLAY when state == 1.
  - Any → IDLE when state == 0.
  - Codes 5–7: hold the current FSM state; show all-blank message.
- Message on HEX3..HEX0 by state:
  - 0 → "----"
  - 1 → "  GO"
  - 2 → "  Lo"
  - 3 → "  HI"
  - 4 → "Good", visible only when the blink phase is on, otherwise all blank.
- Blink:
  - On entry to WIN: phase = on, counter = 0.
  - Counter increments each cycle in WIN. On reaching BLINK_CYCLES−1 it wraps to 0 and toggles the phase.
  - Counter and phase are held at reset values outside WIN.
- Guess counter:
  - Press edge = Guess_button registered 1 last cycle and 0 this cycle.
  - Counts +1 (BCD, ones wrap 9 → 0 with tens carry) on a press edge only while the FSM is in PLAY.
  - Saturates at MAX_COUNT.
  - Cleared while Start_button == 0 or while the FSM is in IDLE. Clear has priority over increment.
- HEX5/HEX4 show the tens/ones digits of the count in every FSM state; HEX5 is blank when tens == 0.
- win = 1 exactly while the FSM is in WIN.

## Timing
- Reset (Reset == 0 at an edge):
  - FSM = IDLE, count = 0, blink counter = 0, phase = on, button history = 1.
  - Outputs: HEX3..HEX0 = '-', HEX4 = 0 pattern, HEX5 = blank, win = 0, guesses = 8'h00.
  - Reset has priority over every other input, including mid-blink.
- All outputs are registered. An input state change at edge N appears on the outputs after edge N+1 (1-cycle latency).
- Guess press held for many cycles counts once. Press edge coincident with Start_button == 0 does not count.
- A press edge in the same cycle that state first reads 4 (FSM still PLAY) counts. The next guess after WIN does not count.
- A blink half-period is exactly BLINK_CYCLES cycles.

## Test plan
- Reset low 2 cycles, then released with state = 0 → HEX3..0 = 7'b0111111, HEX4 = 7'b1000000, HEX5 = 7'h7F, win = 0, guesses = 00.
- state = 1, then 3 single-cycle Guess presses with state = 2 → message "  Lo" (HEX1 = 7'b1000111, HEX0 = 7'b0100011), guesses = 03.
- Guess held low 50 cycles with state = 3 → count increments by exactly 1, message "  HI".
- state = 4 with BLINK_CYCLES = 4 → win = 1; "Good" for 4 cycles, blank for 4, "Good" again. Further presses leave the count unchanged.
- In WIN, Start_button low 1 cycle and state = 1 → guesses = 00, win = 0, message "  GO".
- Count preset to 99 via 99 presses, then 1 more press → guesses stays 99 (HEX5 = HEX4 = 7'b0010000). Reset mid-count → all reset values on the next cycle.
